// File: rtl/stopwatch_ctrl.sv
// mm:ss BCD stopwatch with run/pause, blinking field adjust and a 4-digit
// multiplexed active-low 7-segment driver.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000,
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause_btn,
    input  logic        adj,
    input  logic        sel,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [15:0] time_bcd,
    output logic        running
);

    localparam int PRE_W     = $clog2(CLK_HZ);
    localparam int SCAN_DIV  = CLK_HZ / (4 * SCAN_HZ);
    localparam int SCAN_W    = $clog2(SCAN_DIV);
    localparam int BLINK_DIV = CLK_HZ / 4;
    localparam int BLINK_W   = $clog2(BLINK_DIV);

    localparam logic [PRE_W-1:0]   PRE_MAX     = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0]   ADJ_MAX     = PRE_W'(CLK_HZ / 2 - 1);
    localparam logic [SCAN_W-1:0]  SCAN_MAX    = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX   = BLINK_W'(BLINK_DIV - 1);
    localparam logic [7:0]         MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} run_state_t;

    run_state_t          state, state_next;
    logic                adj_q;
    logic [PRE_W-1:0]    pre;
    logic                adj_edge, sec_tick, adj_tick;
    logic [15:0]         time_next;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          scan_idx;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic [3:0]          digit;
    logic                blank;

    // Returns {carry, next} for a 00..59 BCD seconds field.
    function automatic logic [8:0] sec_inc(input logic [7:0] s);
        logic [8:0] r;
        r = {1'b0, s};
        if (s[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (s[7:4] == 4'd5) begin
                r[7:4] = 4'd0;
                r[8]   = 1'b1;
            end else begin
                r[7:4] = s[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = s[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] m);
        logic [7:0] r;
        r = m;
        if (m == MAX_MIN_BCD) begin
            r = 8'h00;
        end else if (m[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = m[7:4] + 4'd1;
        end else begin
            r[3:0] = m[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Run/pause state machine; the state itself is the running output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PAUSED;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (pause_btn && !adj)
            state_next = (state == RUNNING) ? PAUSED : RUNNING;
    end

    assign running = (state == RUNNING);

    // One prescaler serves both the 1 s run tick and the half-second adjust tick.
    assign adj_edge = adj ^ adj_q;
    assign sec_tick = !adj && !adj_edge && running && (pre == PRE_MAX);
    assign adj_tick = adj && !adj_edge && (pre == ADJ_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adj_q <= 1'b0;
            pre   <= '0;
        end else begin
            adj_q <= adj;
            if (adj_edge)
                pre <= '0;
            else if (adj)
                pre <= (pre == ADJ_MAX) ? '0 : pre + 1'b1;
            else if (running)
                pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
        end
    end

    always_comb begin
        logic [8:0] s_next;
        time_next = time_bcd;
        s_next    = sec_inc(time_bcd[7:0]);
        if (sec_tick) begin
            time_next[7:0] = s_next[7:0];
            if (s_next[8])
                time_next[15:8] = min_inc(time_bcd[15:8]);
        end else if (adj_tick) begin
            if (sel) time_next[7:0]  = s_next[7:0];
            else     time_next[15:8] = min_inc(time_bcd[15:8]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) time_bcd <= 16'h0000;
        else     time_bcd <= time_next;
    end

    always_comb begin
        case (scan_idx)
            2'd0:    digit = time_bcd[3:0];
            2'd1:    digit = time_bcd[7:4];
            2'd2:    digit = time_bcd[11:8];
            default: digit = time_bcd[15:12];
        endcase
        // sel = 1 blinks digits 0/1 (seconds), sel = 0 blinks digits 2/3 (minutes).
        blank = adj && blink_phase && (sel ? !scan_idx[1] : scan_idx[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!adj) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt   <= '0;
            blink_phase <= !blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            an       <= 4'hF;
            seg      <= 8'hFF;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
            an       <= blank ? 4'hF : ~(4'b0001 << scan_idx);
            seg      <= blank ? 8'hFF : seg_decode(digit);
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized scoreboard bench for stopwatch_ctrl; a seconds-based reference
// model predicts every post-edge output, a monitor compares each cycle.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ  = 16;
    localparam int SCAN_HZ = 2;
    localparam int MAX_MIN = 2;
    localparam int DAY     = (MAX_MIN + 1) * 60;
    localparam logic [7:0] SEGTAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        rst, pause_btn, adj, sel;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] time_bcd;
    logic        running;

    logic [28:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          done    = 1'b0;

    // Reference model state: total seconds, prescaler count, edges since reset.
    int          tsec, pre, blink_n, k;
    bit          run, adj_prev;
    logic [3:0]  m_an;
    logic [7:0]  m_seg;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .rst(rst), .pause_btn(pause_btn), .adj(adj), .sel(sel),
        .seg(seg), .an(an), .time_bcd(time_bcd), .running(running)
    );

    function automatic logic [15:0] to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [28:0] got, input logic [28:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        tsec = 0; pre = 0; blink_n = 0; k = 0;
        run = 1'b0; adj_prev = 1'b0;
        m_an = 4'hF; m_seg = 8'hFF;
    endtask

    task automatic model_step(input bit pb, input bit a, input bit s);
        int m, sc, idx, d;
        bit blank, tick_run, tick_adj;
        m = tsec / 60;
        sc = tsec % 60;
        tick_run = 1'b0;
        tick_adj = 1'b0;
        k++;
        if (k % 2 == 0) begin
            idx = (k / 2 - 1) % 4;
            case (idx)
                0: d = sc % 10;
                1: d = sc / 10;
                2: d = m % 10;
                default: d = m / 10;
            endcase
            blank = a && ((blink_n / 4) % 2 == 1) && (s ? (idx < 2) : (idx >= 2));
            m_an  = blank ? 4'hF : 4'(~(1 << idx));
            m_seg = blank ? 8'hFF : SEGTAB[d];
        end
        blink_n = a ? blink_n + 1 : 0;
        if (a != adj_prev) begin
            pre = 0;
        end else if (a) begin
            tick_adj = (pre == CLK_HZ / 2 - 1);
            pre = (pre + 1) % (CLK_HZ / 2);
        end else if (run) begin
            tick_run = (pre == CLK_HZ - 1);
            pre = (pre + 1) % CLK_HZ;
        end
        if (tick_run) tsec = (tsec + 1) % DAY;
        else if (tick_adj) begin
            if (s) tsec = m * 60 + (sc + 1) % 60;
            else   tsec = ((m + 1) % (MAX_MIN + 1)) * 60 + sc;
        end
        if (pb && !a) run = !run;
        adj_prev = a;
    endtask

    task automatic cycle(input bit pb, input bit a, input bit s);
        @(negedge clk);
        pause_btn = pb;
        adj = a;
        sel = s;
        model_step(pb, a, s);
        exp_q.push_back({to_bcd(tsec), run, m_an, m_seg});
    endtask

    task automatic steer_min(input int target);
        int guard = 0;
        while (tsec / 60 != target && guard < 200) begin
            cycle(1'b0, 1'b1, 1'b0);
            guard++;
        end
        check("steer_min", 29'(tsec / 60), 29'(target));
    endtask

    task automatic steer_sec(input int target);
        int guard = 0;
        while (tsec % 60 != target && guard < 1000) begin
            cycle(1'b0, 1'b1, 1'b1);
            guard++;
        end
        check("steer_sec", 29'(tsec % 60), 29'(target));
    endtask

    // Monitor: one comparison per clock whenever a prediction is queued.
    initial begin
        logic [28:0] e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {time_bcd, running, an, seg}, e);
            end
        end
    end

    initial begin
        bit a, s;
        rst = 1'b0; pause_btn = 1'b0; adj = 1'b0; sel = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset_time", 29'(time_bcd), 29'h0);
        check("reset_run", 29'(running), 29'h0);
        check("reset_an", 29'(an), 29'hF);
        check("reset_seg", 29'(seg), 29'hFF);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Idle scan after reset.
        repeat (24) cycle(1'b0, 1'b0, 1'b0);
        check("idle_time", 29'(time_bcd), 29'h0);
        check("idle_run", 29'(running), 29'h0);

        // Minute carry, then freeze on pause.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (60 * CLK_HZ) cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("minute_carry", 29'(time_bcd), 29'h0100);
        check("minute_run", 29'(running), 29'h1);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("frozen_time", 29'(time_bcd), 29'h0100);
        check("frozen_run", 29'(running), 29'h0);

        // Partial-second resume.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (100) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (40) cycle(1'b0, 1'b0, 1'b0);

        // Adjust to MAX_MIN:59 and let one second wrap to 00:00.
        steer_sec(59);
        steer_min(MAX_MIN);
        cycle(1'b0, 1'b0, 1'b0);
        if (!run) cycle(1'b1, 1'b0, 1'b0);
        repeat (CLK_HZ) cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("full_wrap", 29'(time_bcd), 29'h0000);

        // Seconds adjust 58 -> 59 -> 00 with pause pulses ignored.
        steer_min(0);
        steer_sec(58);
        repeat (CLK_HZ / 2) cycle(1'($urandom_range(0, 3) == 0), 1'b1, 1'b1);
        @(posedge clk); #2;
        check("adj_59", 29'(time_bcd), 29'h0059);
        repeat (CLK_HZ / 2) cycle(1'($urandom_range(0, 3) == 0), 1'b1, 1'b1);
        @(posedge clk); #2;
        check("adj_wrap", 29'(time_bcd), 29'h0000);

        // Random mix of pause, adjust and field select.
        a = 1'b0;
        s = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) a = !a;
            if ($urandom_range(0, 9) == 0) s = !s;
            cycle(1'($urandom_range(0, 11) == 0), a, s);
        end

        // Async reset mid-count at 01:23.
        steer_min(1);
        steer_sec(23);
        cycle(1'b0, 1'b0, 1'b0);
        if (!run) cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_time", 29'(time_bcd), 29'h0);
        check("async_run", 29'(running), 29'h0);
        check("async_an", 29'(an), 29'hF);
        check("async_seg", 29'(seg), 29'hFF);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("post_reset_time", 29'(time_bcd), 29'h0);
        check("post_reset_run", 29'(running), 29'h0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (40) cycle(1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #3 done = 1'b1;
        check("queue_drained", 29'(exp_q.size()), 29'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Parametrised mm:ss stopwatch core with integrated 4-digit multiplexed 7-segment driver. Adds features the first-generation stopwatch lacks:
- run/pause control
- adjust mode with field select and blinking field
- configurable clock rate, scan rate and minute limit
- native BCD counting, with no divide/modulo in the datapath
Sits between the debounced button inputs and the board's seg/an pins.

Parameters:
CLK_HZ, 100_000_000, input clock frequency. Even, >= 8*SCAN_HZ.
SCAN_HZ, 1000, full display refresh rate. Digit advances every CLK_HZ/(4*SCAN_HZ) cycles.
MAX_MIN, 59, largest minute value, 1..99. Count wraps MAX_MIN:59 -> 00:00.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
pause_btn  in  1  debounced single-cycle pulse; toggles run/pause
adj  in  1  level; 1 = adjust mode
sel  in  1  adjust field select: 0 = minutes, 1 = seconds
seg  out  8  active-low segments {DP,G,F,E,D,C,B,A}; DP always 1
an  out  4  active-low digit enables; an[0] = seconds ones
time_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones} BCD
running  out  1  1 = counting

Behaviour:
- Reset (async, immediate, no clock needed):
  - time_bcd = 0, running = 0
  - an = 4'b1111, seg = 8'hFF
  - all prescalers, scan index and blink phase = 0
- Run state:
  - running toggles on the cycle after pause_btn = 1.
  - pause_btn is ignored while adj = 1.
- Second prescaler (0..CLK_HZ-1):
  - Increments only when (running & !adj).
  - Holds its value while paused, so resume continues a partial second.
  - Emits a one-cycle tick on the cycle where it equals CLK_HZ-1, then wraps to 0.
- Count on tick:
  - sec_ones 9 -> 0 with carry into sec_tens.
  - sec_tens 5 -> 0 with carry into minutes (BCD).
  - At MAX_MIN:59 -> 00:00.
  - time_bcd updates on the clock edge following the tick cycle.
- Simultaneous tick and pause_btn: the tick is counted (uses the pre-toggle running); the toggle applies next cycle.
- Adjust mode:
  - Rising or falling edge of adj clears the second prescaler.
  - While adj = 1, the prescaler free-runs with period CLK_HZ/2 and emits adj_tick.
  - On adj_tick, sel = 1: seconds +1, 59 -> 00, no carry into minutes.
  - On adj_tick, sel = 0: minutes +1, MAX_MIN -> 00.
  - Changing sel mid-period does not clear the prescaler.
  - running is preserved through adjust. Counting resumes, if running, from a cleared prescaler after adj falls.
- Display scan:
  - Scan counter steps digit index 0,1,2,3,0...
  - On each step, an = one-hot-low for that index and seg = the decoded digit; both are registered.
  - min_tens = 0 is displayed, not blanked.
  - Undefined BCD codes decode to 8'hFF.
- Blink:
  - Phase toggles every CLK_HZ/4 cycles; active only while adj = 1.
  - In phase 1, digits of the selected field are forced off (an bits = 1, seg = 8'hFF when those digits are scanned).
  - The phase counter is cleared when adj = 0.
- Width rules:
  - Counter widths use $clog2 of the respective terminal counts.
  - No width depends on MAX_MIN beyond the 8-bit BCD minutes field.

Test Plan:
Bench parameters: CLK_HZ = 16, SCAN_HZ = 2 (digit step every 2 cycles, blink toggle every 4), MAX_MIN = 2.
1. Reset scan:
   - Stimulus: assert rst, release, no buttons.
   - Required: during reset an = 1111, seg = FF, time_bcd = 0000. After release, an cycles 1110, 1101, 1011, 0111 every 2 cycles with seg = C0. time_bcd stays 0000 and running = 0 indefinitely.
2. Minute carry:
   - Stimulus: pulse pause_btn, then run 60*16 cycles.
   - Required: running = 1, time_bcd = 16'h0100.
   - Stimulus: one more pulse.
   - Required: running = 0, time_bcd frozen.
3. Partial-second resume:
   - Stimulus: start, wait 10 cycles, pause, idle 100 cycles, resume.
   - Required: sec_ones reaches 1 exactly 6 enabled cycles after resume (prescaler held). Nothing changes while paused.
4. Full wrap:
   - Stimulus: adjust to 02:59 (adj = 1; sel = 0 twice; sel = 1 59 times at 8-cycle intervals), adj = 0, run one second.
   - Required: time_bcd = 0000.
5. Adjust seconds:
   - Stimulus: from 00:58, adj = 1, sel = 1.
   - Required: after 8 cycles 00:59; after 16 cycles 00:00 with minutes unchanged. an[1:0] held high in blink phase 1. pause_btn pulses are ignored.
6. Async reset mid-count:
   - Stimulus: at 01:23 running, raise rst between clock edges.
   - Required: time_bcd = 0000, running = 0, an = 1111 before the next posedge. Counting stays stopped after release until pause_btn.
